// File: rtl/data_memory_pkg.sv
// Shared definitions for the data-memory responder: handshake FSM encoding,
// default data-segment base address and the reset image of the first two words.
package data_memory_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;
  localparam logic [31:0] INIT_WORD0        = 32'd100;
  localparam logic [31:0] INIT_WORD1        = 32'd200;

endpackage

// File: rtl/data_memory_responder_if.sv
// Load/store request/response bus between the datapath (master) and the
// data-memory responder (slave).
interface data_memory_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/data_memory_responder_mem_word_array.sv
// Word storage for the responder: DEPTH_WORDS x 32, one write and one
// combinational read port, asynchronously reloaded with the data-segment image.
module mem_word_array
  import data_memory_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_index,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        r_mem[i] <= (i == 0) ? INIT_WORD0 : (i == 1) ? INIT_WORD1 : 32'd0;
      end
    end else if (i_we) begin
      r_mem[i_index] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_index];

endmodule

// File: rtl/data_memory_responder.sv
// Responder end of the load/store bus: one request at a time, LATENCY cycles to response.
// Optional build macro MISALIGN_ERR_EN rejects accesses with addr[1:0] != 0.
module data_memory_responder
  import data_memory_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          DEPTH_WORDS = 64,
  parameter int          LATENCY     = 2
) (
  input  logic                     clock,
  input  logic                     clear_n,
  data_memory_responder_if.slave   bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_cnt;
  logic             r_req_ready;
  logic [31:0]      r_rdata;
  logic             r_error;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic             r_write;

  logic             w_accept;
  logic             w_commit;
  logic [31:0]      w_op_addr;
  logic [31:0]      w_op_wdata;
  logic             w_op_write;
  logic [29:0]      w_word_off;
  logic             w_in_range;
  logic             w_error;
  logic             w_we;
  logic [31:0]      w_mem_rdata;

  assign w_accept = bus.req_valid && r_req_ready;

  // With LATENCY=1 the access happens on the accept edge itself, so the
  // operands come straight off the bus instead of the capture registers.
  assign w_op_addr  = (r_state == ST_IDLE) ? bus.req_addr  : r_addr;
  assign w_op_wdata = (r_state == ST_IDLE) ? bus.req_wdata : r_wdata;
  assign w_op_write = (r_state == ST_IDLE) ? bus.req_write : r_write;
  assign w_commit   = ((r_state == ST_BUSY) && (r_cnt == 4'd0)) ||
                      ((LATENCY == 1) && w_accept);

  // Word offset assumes a word-aligned base; the >= check runs on the raw
  // address so addresses below the base never wrap into range.
  assign w_word_off = w_op_addr[31:2] - BASE_ADDR[31:2];
  assign w_in_range = (w_op_addr >= BASE_ADDR) && (w_word_off < 30'(DEPTH_WORDS));
`ifdef MISALIGN_ERR_EN
  assign w_error = !w_in_range || (w_op_addr[1:0] != 2'b00);
`else
  logic [1:0] w_unused_lsb;
  assign w_unused_lsb = w_op_addr[1:0];
  assign w_error      = !w_in_range;
`endif
  assign w_we = w_commit && w_op_write && !w_error;

  mem_word_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_mem (
    .clock   (clock),
    .clear_n (clear_n),
    .i_we    (w_we),
    .i_index (w_word_off[IDX_W-1:0]),
    .i_wdata (w_op_wdata),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = (LATENCY == 1) ? ST_RESP : ST_BUSY;
      ST_BUSY: if (r_cnt == 4'd0) w_next = ST_RESP;
      ST_RESP: if (bus.resp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_cnt       <= 4'd0;
      r_req_ready <= 1'b0;
      r_rdata     <= 32'd0;
      r_error     <= 1'b0;
    end else begin
      r_req_ready <= (w_next == ST_IDLE);
      if (w_accept)                              r_cnt <= 4'(LATENCY - 1);
      else if (r_state == ST_BUSY && r_cnt != 0) r_cnt <= r_cnt - 4'd1;
      if (w_commit) begin
        r_rdata <= (w_error || w_op_write) ? 32'd0 : w_mem_rdata;
        r_error <= w_error;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_addr  <= bus.req_addr;
      r_wdata <= bus.req_wdata;
      r_write <= bus.req_write;
    end
  end

  always_comb begin
    bus.req_ready  = r_req_ready;
    bus.resp_valid = (r_state == ST_RESP);
    bus.resp_rdata = r_rdata;
    bus.resp_error = r_error;
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: directed cases plus random traffic
// against an array-based memory model; a monitor checks every response.
module tb_data_memory_responder;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 64;
  localparam int          LAT   = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  logic clock   = 1'b0;
  logic clear_n = 1'b0;
  int   cyc     = 0;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   hold_cnt = 0;
  logic [31:0] ref_mem [DEPTH];
  exp_t sbq [$];

  data_memory_responder_if bus ();

  data_memory_responder #(
    .BASE_ADDR   (BASE),
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic void fail_now(string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout/unexpected expected event (t=%0t)", nm, $time);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
    ref_mem[0] = 32'd100;
    ref_mem[1] = 32'd200;
  endfunction

  // Memory behaviour from plain 64-bit byte arithmetic.
  function automatic void model(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output logic err);
    longint ua  = a;
    longint ub  = BASE;
    longint off = ua - ub;
    err = (off < 0) || (off / 4 >= DEPTH);
`ifdef MISALIGN_ERR_EN
    if (a % 4 != 0) err = 1'b1;
`endif
    rd = 32'd0;
    if (!err) begin
      if (wr) ref_mem[int'(off / 4)] = wd;
      else    rd = ref_mem[int'(off / 4)];
    end
  endfunction

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] wd);
    int   waited = 0;
    exp_t e;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    while (!bus.req_ready && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    if (!bus.req_ready) begin
      fail_now("req_accept");
      bus.req_valid = 1'b0;
      return;
    end
    e.acc = cyc;
    model(wr, a, wd, e.rdata, e.err);
    sbq.push_back(e);
    @(negedge clock);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sbq.size() != 0 && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (sbq.size() != 0) fail_now("drain");
  endtask

  initial begin
    bus.resp_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (hold_cnt > 0) begin
        bus.resp_ready = 1'b0;
        if (bus.resp_valid) hold_cnt--;
      end else begin
        bus.resp_ready = ($urandom_range(0, 2) != 0);
      end
    end
  end

  initial begin
    bit   seen = 0;
    exp_t e;
    forever begin
      @(negedge clock);
      if (!clear_n) begin
        seen = 0;
      end else if (bus.resp_valid) begin
        if (sbq.size() == 0) begin
          fail_now("resp_unexpected");
        end else begin
          e = sbq[0];
          if (!seen) chk("latency", 32'(cyc - e.acc - 1), 32'(LAT));
          seen = 1;
          chk("resp_rdata", bus.resp_rdata, e.rdata);
          chk("resp_error", {31'd0, bus.resp_error}, {31'd0, e.err});
          chk("req_ready_in_resp", {31'd0, bus.req_ready}, 32'd0);
          if (bus.resp_ready) begin
            void'(sbq.pop_front());
            seen = 0;
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'd0;
    bus.req_wdata = 32'd0;
    model_reset();
    repeat (3) @(negedge clock);
    chk("rst_req_ready",  {31'd0, bus.req_ready},  32'd0);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata,          32'd0);
    chk("rst_resp_error", {31'd0, bus.resp_error}, 32'd0);
    clear_n = 1'b1;
    #1 chk("ready_before_edge", {31'd0, bus.req_ready}, 32'd0);
    @(negedge clock);
    chk("ready_after_edge", {31'd0, bus.req_ready}, 32'd1);

    do_req(0, BASE, 0);
    do_req(0, BASE + 32'h4, 0);
    do_req(1, BASE + 32'h8, 32'd200);
    do_req(0, BASE + 32'h8, 0);

    do_req(1, BASE + 32'h100, 32'hDEAD_BEEF);
    do_req(0, 32'h1000_FFFC, 0);
    do_req(0, BASE, 0);
    do_req(1, 32'hFFFF_FFFC, 32'd5);
    do_req(0, BASE + 32'hFC, 0);

    wait_drain();
    hold_cnt = 5;
    do_req(0, BASE + 32'h4, 0);
    do_req(0, BASE, 0);

    wait_drain();
    do_req(1, BASE + 32'hC, 32'd7);
    clear_n = 1'b0;
    #1;
    chk("async_req_ready",  {31'd0, bus.req_ready},  32'd0);
    chk("async_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("async_resp_rdata", bus.resp_rdata,          32'd0);
    chk("async_resp_error", {31'd0, bus.resp_error}, 32'd0);
    sbq.delete();
    model_reset();
    @(negedge clock);
    clear_n = 1'b1;
    @(negedge clock);
    do_req(0, BASE + 32'hC, 0);

    do_req(0, BASE + 32'h2, 0);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: a = BASE + {$urandom_range(0, DEPTH - 1), 2'b00};
        6:                a = BASE + $urandom_range(0, DEPTH * 4 - 1);
        7:                a = BASE + DEPTH * 4 + $urandom_range(0, 15);
        8:                a = BASE - 32'($urandom_range(1, 16));
        default:          a = 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
      endcase
      do_req($urandom_range(0, 1) == 1, a, $urandom);
    end

    wait_drain();
    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
